counter_7seg_multi: RTL
=======================

Name: counter_7seg_multi

Overview:
- Parametrised successor to the single-digit key-driven 7-segment counter.
- Multi-digit up/down counter, hex or decimal (BCD) radix, driven by three board push-buttons (active-low when pressed).
- Each key is synchronised and debounced on chip, and produces exactly one count event per press.
- Drives DIGITS seven-segment displays directly; sits at board top level between the KEY pins and the HEX pins.

Parameters:
- DIGITS, 4, number of displayed digits (1..8).
- DECIMAL, 0, 0 = hex digits 0..F; 1 = BCD digits 0..9.
- SATURATE, 0, 0 = wrap at max/min; 1 = hold at max/min.
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a key level is accepted (>=2).
- BLANK_LZ, 0, 1 = blank leading zero digits; digit 0 is never blanked.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- key_clr_n  input  1  raw clear button, low = pressed
- key_inc_n  input  1  raw increment button, low = pressed
- key_dec_n  input  1  raw decrement button, low = pressed
- value  output  4*DIGITS  counter value, one nibble per digit, digit 0 = bits [3:0]
- hex  output  7*DIGITS  segments per digit, digit d = bits [7d+6:7d], bit0 = a ... bit6 = g, active-low
- limit  output  1  one-cycle pulse when an event wraps or is saturated

Behaviour:
- Reset (rst_n low, asynchronous):
  - value = 0, limit = 0.
  - All synchroniser and debounce state returns to "released" (1); debounce counters = 0.
  - hex shows 0 on every digit, or blanked digits if BLANK_LZ = 1.
- Per-key input path:
  - Raw input goes through a 2-flop synchroniser.
  - Debouncer holds an accepted level plus a counter.
  - Counter clears whenever the synchronised level equals the accepted level; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES - 1, the accepted level flips and the counter clears.
  - A press event is a one-cycle pulse on the accepted 1->0 transition. A release generates no event.
- Glitches shorter than DEBOUNCE_CYCLES cycles produce no event.
- Latency: value changes on the clock edge after the event pulse. Total delay from a clean raw falling edge is DEBOUNCE_CYCLES + 3 cycles.
- Event priority, evaluated in a single cycle:
  - clr event: value = 0; inc and dec in the same cycle are ignored.
  - inc and dec both (no clr): no change, limit = 0.
  - inc only: increment. dec only: decrement.
- Arithmetic:
  - Per-digit ripple carry/borrow. Digit max is F, or 9 when DECIMAL = 1.
  - Increment of the all-max value: wraps to 0 (SATURATE = 0) or holds (SATURATE = 1); limit pulses either way.
  - Decrement of 0: wraps to all-max or holds; limit pulses.
  - limit is registered, asserted in the same cycle value updates, and lasts exactly one cycle.
- Display:
  - Combinational from value; each nibble decoded with the standard hex 7-segment font, active-low.
  - Blanked digit = 7'b1111111.
  - With BLANK_LZ = 1, digit d (d > 0) is blanked iff it and all higher digits are 0.
- Holding a key produces a single event; no auto-repeat.
- rst_n asserted mid-debounce or mid-press: state is discarded. After rst_n release, a key still held is first accepted after DEBOUNCE_CYCLES cycles and then yields one event.

Decomposition:
- Shared package/header (counter_7seg_pkg): SEG_BLANK, the 16-entry hex segment font, digit-max constants HEX_MAX = 4'hF and DEC_MAX = 4'd9.
- Sub-module key_debounce:
  - Parameter CYCLES.
  - Ports clk, rst_n, key_n, pressed (level), press (one-cycle pulse).
  - Instantiated three times.
- Segment decode reuses the existing bin_to_7seg_converter, one instance per digit, with a blanking mux after it.

Test Plan (DIGITS = 2, DEBOUNCE_CYCLES = 4 unless noted):
- Reset, then one clean inc press held 20 cycles -> value 8'h01 exactly DEBOUNCE_CYCLES + 3 cycles after the raw edge; no further change while held or on release.
- Inc glitches low for 2 cycles, repeated 5 times -> value unchanged; no event pulse.
- DECIMAL = 1: preload to 8'h09 via 9 presses, then inc -> 8'h10. Press dec twice from 8'h00 -> 8'h99, then 8'h98; limit pulses once, on the first dec.
- DECIMAL = 0, SATURATE = 1: from 8'hFF press inc -> stays 8'hFF, limit pulses 1 cycle. From 8'h00 press dec -> stays 8'h00, limit pulses.
- Raw inc, dec and clr falling on the same cycle, starting from 8'h05 -> value 8'h00. Inc and dec alone on the same cycle from 8'h05 -> stays 8'h05, limit = 0.
- BLANK_LZ = 1, value 8'h07 -> hex[13:7] = 7'h7F and hex[6:0] = font(7). Assert rst_n mid-press -> value 0 immediately; key held through release yields exactly one event.

Source files
------------

// File: rtl/counter_7seg_pkg.sv
// Shared display constants and the hex font for the multi-digit key counter.
// Segment patterns are active-low with bit0 = a ... bit6 = g.
package counter_7seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] HEX_MAX   = 4'hF;
  localparam logic [3:0] DEC_MAX   = 4'd9;

  function automatic logic [6:0] seg_font(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin_to_7seg_converter.sv
// One-nibble hex to active-low seven-segment decoder.
module bin_to_7seg_converter
  import counter_7seg_pkg::*;
(
  input  logic [3:0] bin,
  output logic [6:0] seg
);

  assign seg = seg_font(bin);

endmodule

// File: rtl/key_debounce.sv
// Synchronise and debounce one active-low push-button; pulse once per accepted press.
module key_debounce #(
  parameter int CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pressed,
  output logic press
);

  localparam int CW = $clog2(CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // The accepted level only moves after CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(CYCLES - 1)) begin
        r_level <= r_sync2;
        r_press <= ~r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign pressed = ~r_level;
  assign press   = r_press;

endmodule

// File: rtl/counter_7seg_multi.sv
// Multi-digit hex/BCD up/down counter driven by three debounced keys,
// with direct active-low seven-segment outputs and optional leading-zero blanking.
module counter_7seg_multi
  import counter_7seg_pkg::*;
#(
  parameter int DIGITS          = 4,
  parameter int DECIMAL         = 0,
  parameter int SATURATE        = 0,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BLANK_LZ        = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_clr_n,
  input  logic                key_inc_n,
  input  logic                key_dec_n,
  output logic [4*DIGITS-1:0] value,
  output logic [7*DIGITS-1:0] hex,
  output logic                limit
);

  localparam int         W    = 4 * DIGITS;
  localparam logic [3:0] DMAX = (DECIMAL != 0) ? DEC_MAX : HEX_MAX;

  logic [W-1:0] r_value;
  logic         r_limit;
  logic         w_clr;
  logic         w_inc;
  logic         w_dec;
  logic [2:0]   w_unused_lvl;
  logic [W-1:0] w_inc_val;
  logic [W-1:0] w_dec_val;
  logic         w_inc_wrap;
  logic         w_dec_wrap;
  logic [6:0]   w_font [DIGITS];
  logic [DIGITS-1:0] w_blank;

  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_clr (
    .clk(clk), .rst_n(rst_n), .key_n(key_clr_n), .pressed(w_unused_lvl[2]), .press(w_clr)
  );
  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk(clk), .rst_n(rst_n), .key_n(key_inc_n), .pressed(w_unused_lvl[1]), .press(w_inc)
  );
  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_dec (
    .clk(clk), .rst_n(rst_n), .key_n(key_dec_n), .pressed(w_unused_lvl[0]), .press(w_dec)
  );

  // Ripple carry/borrow across digits; a carry/borrow out of the top digit means wrap.
  always_comb begin
    logic       c;
    logic       b;
    logic [3:0] dg;
    w_inc_val = r_value;
    w_dec_val = r_value;
    c  = 1'b1;
    b  = 1'b1;
    dg = 4'h0;
    for (int d = 0; d < DIGITS; d++) begin
      dg = r_value[4*d +: 4];
      if (c && (dg == DMAX)) begin
        w_inc_val[4*d +: 4] = 4'h0;
      end else if (c) begin
        w_inc_val[4*d +: 4] = dg + 4'h1;
        c = 1'b0;
      end else begin
        w_inc_val[4*d +: 4] = dg;
      end
      if (b && (dg == 4'h0)) begin
        w_dec_val[4*d +: 4] = DMAX;
      end else if (b) begin
        w_dec_val[4*d +: 4] = dg - 4'h1;
        b = 1'b0;
      end else begin
        w_dec_val[4*d +: 4] = dg;
      end
    end
    w_inc_wrap = c;
    w_dec_wrap = b;
  end

  // Clear dominates; simultaneous inc and dec cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
      r_limit <= 1'b0;
    end else begin
      r_limit <= 1'b0;
      if (w_clr) begin
        r_value <= '0;
      end else if (w_inc && !w_dec) begin
        r_limit <= w_inc_wrap;
        if (!(w_inc_wrap && (SATURATE != 0))) begin
          r_value <= w_inc_val;
        end
      end else if (w_dec && !w_inc) begin
        r_limit <= w_dec_wrap;
        if (!(w_dec_wrap && (SATURATE != 0))) begin
          r_value <= w_dec_val;
        end
      end
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    bin_to_7seg_converter u_seg (
      .bin(r_value[4*g +: 4]),
      .seg(w_font[g])
    );
  end

  // A digit blanks only when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    logic hz;
    hz  = 1'b1;
    hex = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      hz         = hz && (r_value[4*d +: 4] == 4'h0);
      w_blank[d] = (BLANK_LZ != 0) && (d > 0) && hz;
      hex[7*d +: 7] = w_blank[d] ? SEG_BLANK : w_font[d];
    end
  end

  assign value = r_value;
  assign limit = r_limit;

endmodule
